// File: rtl/bid_sched_pkg.sv
// Shared types and constants for the sealed-bid round scheduler.
package bid_sched_pkg;

   localparam int unsigned NUM_BIDDERS = 3;
   localparam int unsigned PTR_W       = 2;
   localparam int unsigned BID_X       = 0;
   localparam int unsigned BID_Y       = 1;
   localparam int unsigned BID_Z       = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_RESOLVE = 2'd2
   } state_e;

   // Round-robin pointer update: priority moves to the bidder after the one granted.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [NUM_BIDDERS-1:0] gnt);
      logic [PTR_W-1:0] p;
      p = PTR_W'(BID_X);
      if (gnt[BID_X])      p = PTR_W'(BID_Y);
      else if (gnt[BID_Y]) p = PTR_W'(BID_Z);
      return p;
   endfunction

endpackage

// File: rtl/bid_round_sched_rr_arb3.sv
// Three-way round-robin arbiter: one-hot grant, ptr names the highest-priority bidder.
module rr_arb3
   import bid_sched_pkg::*;
(
   input  logic [NUM_BIDDERS-1:0] req_i,
   input  logic [PTR_W-1:0]       ptr_i,
   output logic [NUM_BIDDERS-1:0] gnt_o
);

   logic [NUM_BIDDERS-1:0] rot;
   logic [NUM_BIDDERS-1:0] pick;

   // Rotate so the pointer bidder sits at bit 0, pick lowest set bit, rotate back.
   always_comb begin
      rot   = req_i;
      pick  = '0;
      gnt_o = '0;
      case (ptr_i)
         2'd1:    rot = {req_i[0], req_i[2], req_i[1]};
         2'd2:    rot = {req_i[1], req_i[0], req_i[2]};
         default: rot = req_i;
      endcase
      if (rot[0])      pick = 3'b001;
      else if (rot[1]) pick = 3'b010;
      else if (rot[2]) pick = 3'b100;
      case (ptr_i)
         2'd1:    gnt_o = {pick[1], pick[0], pick[2]};
         2'd2:    gnt_o = {pick[0], pick[2], pick[1]};
         default: gnt_o = pick;
      endcase
   end

endmodule

// File: rtl/bid_round_sched.sv
// Timed bidding-round scheduler with round-robin bid acceptance and max tracking.
// Optional RETRACT_EN adds a retract port and runner-up tracking.
module bid_round_sched
   import bid_sched_pkg::*;
#(
   parameter int unsigned AMT_W = 16,
   parameter int unsigned TMR_W = 4
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [TMR_W-1:0]             timer_load,
   input  logic [NUM_BIDDERS-1:0]       mask,
   input  logic [NUM_BIDDERS-1:0]       bid_req,
   input  logic [NUM_BIDDERS*AMT_W-1:0] bid_amt,
`ifdef RETRACT_EN
   input  logic [NUM_BIDDERS-1:0]       retract,
`endif
   output logic [NUM_BIDDERS-1:0]       bid_gnt,
   output logic                         bid_low,
   output logic                         busy,
   output logic                         round_over,
   output logic [NUM_BIDDERS-1:0]       winner,
   output logic [AMT_W-1:0]             max_bid
);

   state_e                 state_q, state_d;
   logic [TMR_W-1:0]       timer_q, timer_d;
   logic [NUM_BIDDERS-1:0] mask_q, mask_d;
   logic [AMT_W-1:0]       max_q, max_d;
   logic [NUM_BIDDERS-1:0] leader_q, leader_d;
   logic [NUM_BIDDERS-1:0] winner_q, winner_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic                   low_q, low_d;
   logic                   over_q, over_d;
   logic                   busy_q, busy_d;
`ifdef RETRACT_EN
   logic [NUM_BIDDERS-1:0] ru_id_q, ru_id_d;
   logic [AMT_W-1:0]       ru_amt_q, ru_amt_d;
   logic                   ret_hit;
`endif

   logic                   run_c;
   logic [NUM_BIDDERS-1:0] arb_req;
   logic [NUM_BIDDERS-1:0] gnt;
   logic [AMT_W-1:0]       acc_amt;

   assign run_c = (state_q == ST_RUN);

   // A valid retract freezes arbitration for that cycle.
`ifdef RETRACT_EN
   assign ret_hit = run_c && ((retract & (leader_q | ru_id_q)) != '0);
   assign arb_req = (run_c && !ret_hit) ? (bid_req & mask_q) : '0;
`else
   assign arb_req = run_c ? (bid_req & mask_q) : '0;
`endif

   rr_arb3 u_arb (
      .req_i (arb_req),
      .ptr_i (ptr_q),
      .gnt_o (gnt)
   );

   assign bid_gnt = gnt;

   always_comb begin
      acc_amt = '0;
      for (int b = 0; b < NUM_BIDDERS; b++) begin
         if (gnt[b]) acc_amt = bid_amt[b*AMT_W +: AMT_W];
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      mask_d   = mask_q;
      max_d    = max_q;
      leader_d = leader_q;
      winner_d = winner_q;
      ptr_d    = ptr_q;
      low_d    = 1'b0;
      over_d   = 1'b0;
`ifdef RETRACT_EN
      ru_id_d  = ru_id_q;
      ru_amt_d = ru_amt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               timer_d  = timer_load;
               mask_d   = mask;
               max_d    = '0;
               leader_d = '0;
               winner_d = '0;
`ifdef RETRACT_EN
               ru_id_d  = '0;
               ru_amt_d = '0;
`endif
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (gnt != '0) begin
               ptr_d = next_ptr(gnt);
               if (acc_amt > max_q) begin
`ifdef RETRACT_EN
                  if (gnt != leader_q) begin
                     ru_id_d  = leader_q;
                     ru_amt_d = max_q;
                  end
`endif
                  max_d    = acc_amt;
                  leader_d = gnt;
               end else begin
                  low_d = 1'b1;
`ifdef RETRACT_EN
                  if (gnt != leader_q && (ru_id_q == '0 || acc_amt > ru_amt_q)) begin
                     ru_id_d  = gnt;
                     ru_amt_d = acc_amt;
                  end
`endif
               end
            end
`ifdef RETRACT_EN
            else if (ret_hit) begin
               // Leader retract promotes the runner-up; both retracting empties the board.
               if ((retract & leader_q) != '0) begin
                  if ((retract & ru_id_q) != '0) begin
                     max_d    = '0;
                     leader_d = '0;
                  end else begin
                     max_d    = ru_amt_q;
                     leader_d = ru_id_q;
                  end
               end
               ru_id_d  = '0;
               ru_amt_d = '0;
            end
`endif
            if (timer_q == '0) state_d = ST_RESOLVE;
            else               timer_d = timer_q - TMR_W'(1);
         end
         ST_RESOLVE: begin
            winner_d = leader_q;
            over_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         mask_q   <= '0;
         max_q    <= '0;
         leader_q <= '0;
         winner_q <= '0;
         ptr_q    <= PTR_W'(BID_X);
         low_q    <= 1'b0;
         over_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef RETRACT_EN
         ru_id_q  <= '0;
         ru_amt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         mask_q   <= mask_d;
         max_q    <= max_d;
         leader_q <= leader_d;
         winner_q <= winner_d;
         ptr_q    <= ptr_d;
         low_q    <= low_d;
         over_q   <= over_d;
         busy_q   <= busy_d;
`ifdef RETRACT_EN
         ru_id_q  <= ru_id_d;
         ru_amt_q <= ru_amt_d;
`endif
      end
   end

   assign bid_low    = low_q;
   assign busy       = busy_q;
   assign round_over = over_q;
   assign winner     = winner_q;
   assign max_bid    = max_q;

endmodule

// File: tb/tb_bid_round_sched.sv
// Scoreboard bench for bid_round_sched: expected grants and round results are queued
// as bids are posted and checked as the DUT grants and resolves.
module tb_bid_round_sched;

   localparam int unsigned AMT_W = 16;
   localparam int unsigned TMR_W = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [TMR_W-1:0]     timer_load;
   logic [2:0]           mask;
   logic [2:0]           bid_req;
   logic [3*AMT_W-1:0]   bid_amt;
`ifdef RETRACT_EN
   logic [2:0]           retract;
`endif
   logic [2:0]           bid_gnt;
   logic                 bid_low;
   logic                 busy;
   logic                 round_over;
   logic [2:0]           winner;
   logic [AMT_W-1:0]     max_bid;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0]       win;
      logic [AMT_W-1:0] amt;
      int               lows;
      int               len;
   } res_t;

   int   exp_gnt_q[$];
   res_t exp_res_q[$];

   always #5 clk = ~clk;

   bid_round_sched #(.AMT_W(AMT_W), .TMR_W(TMR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .timer_load (timer_load),
      .mask       (mask),
      .bid_req    (bid_req),
      .bid_amt    (bid_amt),
`ifdef RETRACT_EN
      .retract    (retract),
`endif
      .bid_gnt    (bid_gnt),
      .bid_low    (bid_low),
      .busy       (busy),
      .round_over (round_over),
      .winner     (winner),
      .max_bid    (max_bid)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; timer_load = '0; mask = '0; bid_req = '0; bid_amt = '0;
`ifdef RETRACT_EN
      retract = '0;
`endif
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_gnt_q.delete();
      exp_res_q.delete();
   endtask

   task automatic post_bid(input int b, input logic [AMT_W-1:0] a);
      bid_amt[b*AMT_W +: AMT_W] = a;
      bid_req[b] = 1'b1;
   endtask

   task automatic push_res(input logic [2:0] w, input logic [AMT_W-1:0] a, input int lows, input int len);
      res_t r;
      r.win = w; r.amt = a; r.lows = lows; r.len = len;
      exp_res_q.push_back(r);
   endtask

   task automatic do_start(input logic [TMR_W-1:0] tl, input logic [2:0] m);
      @(negedge clk);
      start = 1'b1; timer_load = tl; mask = m;
      n_checks++;
      if (bid_gnt !== 3'b000) begin
         n_fail++;
         $display("FAIL idle_gnt: bid_gnt=%b required 000", bid_gnt);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_round(input int budget);
      int         cyc;
      int         lows;
      int         e;
      logic       done;
      logic [2:0] seen;
      res_t       r;
      cyc = 0; lows = 0; done = 1'b0;
      while (!done && cyc < budget) begin
         @(negedge clk);
         cyc++;
         seen = bid_gnt;
         if (bid_low === 1'b1) lows++;
         if (seen !== 3'b000) begin
            n_checks++;
            if (exp_gnt_q.size() == 0) begin
               n_fail++;
               $display("FAIL grant: bid_gnt=%b required 000 at cycle %0d", seen, cyc);
            end else begin
               e = exp_gnt_q.pop_front();
               if (seen !== 3'(1 << e)) begin
                  n_fail++;
                  $display("FAIL grant: bid_gnt=%b required %b at cycle %0d", seen, 3'(1 << e), cyc);
               end
            end
         end
         if (round_over === 1'b1) begin
            done = 1'b1;
            n_checks++;
            if (exp_res_q.size() == 0) begin
               n_fail++;
               $display("FAIL round_over: unexpected pulse, required none");
            end else begin
               r = exp_res_q.pop_front();
               n_checks += 4;
               if (winner !== r.win) begin
                  n_fail++; $display("FAIL winner: got %b required %b", winner, r.win);
               end
               if (max_bid !== r.amt) begin
                  n_fail++; $display("FAIL max_bid: got %0d required %0d", max_bid, r.amt);
               end
               if (lows != r.lows) begin
                  n_fail++; $display("FAIL bid_low_count: got %0d required %0d", lows, r.lows);
               end
               if (cyc != r.len) begin
                  n_fail++; $display("FAIL round_len: round_over at cycle %0d required %0d", cyc, r.len);
               end
            end
            if (busy !== 1'b0) begin
               n_fail++; $display("FAIL busy_end: got %b required 0", busy);
            end
         end else begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_fail++; $display("FAIL busy_run: got %b required 1 at cycle %0d", busy, cyc);
            end
         end
         @(posedge clk); #1;
         bid_req = bid_req & ~seen;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL round_timeout: no round_over within %0d cycles, required one", budget);
      end
      n_checks++;
      if (exp_gnt_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_grants: %0d grants outstanding, required 0", exp_gnt_q.size());
      end
      exp_gnt_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks += 3;
      if ({bid_gnt, bid_low, busy, round_over} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: gnt/low/busy/over=%b required 000000", {bid_gnt, bid_low, busy, round_over});
      end
      if (winner !== 3'b000) begin
         n_fail++; $display("FAIL reset_winner: got %b required 000", winner);
      end
      if (max_bid !== '0) begin
         n_fail++; $display("FAIL reset_max: got %0d required 0", max_bid);
      end
   endtask

   task automatic test_single_bid();
      do_reset();
      post_bid(0, 16'd10);
      exp_gnt_q.push_back(0);
      push_res(3'b001, 16'd10, 0, 6);
      do_start(4'd3, 3'b111);
      run_round(20);
   endtask

   task automatic test_three_bidders();
      do_reset();
      post_bid(0, 16'd5); post_bid(1, 16'd9); post_bid(2, 16'd7);
      exp_gnt_q.push_back(0); exp_gnt_q.push_back(1); exp_gnt_q.push_back(2);
      push_res(3'b010, 16'd9, 1, 6);
      do_start(4'd3, 3'b111);
      run_round(20);
   endtask

   task automatic test_mask();
      do_reset();
      post_bid(1, 16'd50);
      push_res(3'b000, 16'd0, 0, 5);
      do_start(4'd2, 3'b101);
      run_round(20);
      bid_req = '0;
   endtask

   task automatic test_tie();
      do_reset();
      post_bid(0, 16'd20); post_bid(1, 16'd20);
      exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
      push_res(3'b001, 16'd20, 1, 6);
      do_start(4'd3, 3'b111);
      run_round(20);
   endtask

   task automatic test_last_cycle();
      do_reset();
      post_bid(2, 16'd33);
      exp_gnt_q.push_back(2);
      push_res(3'b100, 16'd33, 0, 3);
      do_start(4'd0, 3'b111);
      run_round(10);
   endtask

   task automatic test_start_ignored();
      do_reset();
      post_bid(0, 16'd7);
      exp_gnt_q.push_back(0);
      push_res(3'b001, 16'd7, 0, 4);
      do_start(4'd1, 3'b001);
      start = 1'b1; timer_load = 4'd15;
      run_round(25);
      start = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      post_bid(0, 16'd3);
      exp_gnt_q.push_back(0);
      push_res(3'b001, 16'd3, 0, 5);
      do_start(4'd2, 3'b111);
      run_round(20);
      // pointer now at y: z wins arbitration before x
      post_bid(0, 16'd4); post_bid(2, 16'd6);
      exp_gnt_q.push_back(2); exp_gnt_q.push_back(0);
      push_res(3'b100, 16'd6, 1, 5);
      do_start(4'd2, 3'b111);
      run_round(20);
   endtask

   task automatic test_reset_mid_run();
      int overs;
      do_reset();
      post_bid(0, 16'd10);
      do_start(4'd5, 3'b111);
      @(negedge clk);
      n_checks++;
      if (bid_gnt !== 3'b001) begin
         n_fail++; $display("FAIL mid_gnt: got %b required 001", bid_gnt);
      end
      @(posedge clk); #1;
      bid_req = '0;
      @(negedge clk);
      n_checks++;
      if (max_bid !== 16'd10 || busy !== 1'b1) begin
         n_fail++; $display("FAIL mid_pre: max_bid=%0d busy=%b required 10 and 1", max_bid, busy);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || max_bid !== '0 || winner !== 3'b000) begin
         n_fail++;
         $display("FAIL mid_reset: busy=%b max_bid=%0d winner=%b required 0 0 000", busy, max_bid, winner);
      end
      overs = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (round_over === 1'b1) overs++;
      end
      n_checks++;
      if (overs != 0) begin
         n_fail++; $display("FAIL mid_no_over: %0d round_over pulses, required 0", overs);
      end
   endtask

`ifdef RETRACT_EN
   task automatic test_retract();
      int         cyc;
      logic       done;
      logic [2:0] seen;
      do_reset();
      post_bid(0, 16'd10); post_bid(1, 16'd15);
      do_start(4'd5, 3'b111);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         seen = bid_gnt;
         n_checks++;
         if (seen !== 3'(1 << i)) begin
            n_fail++; $display("FAIL ret_gnt%0d: got %b required %b", i, seen, 3'(1 << i));
         end
         @(posedge clk); #1;
         bid_req = bid_req & ~seen;
      end
      @(negedge clk);
      n_checks++;
      if (max_bid !== 16'd15) begin
         n_fail++; $display("FAIL ret_pre: max_bid=%0d required 15", max_bid);
      end
      retract = 3'b010;
      post_bid(2, 16'd1);
      n_checks++;
      if (bid_gnt !== 3'b000) begin
         n_fail++; $display("FAIL ret_suppress: bid_gnt=%b required 000", bid_gnt);
      end
      @(posedge clk); #1;
      retract = '0;
      @(negedge clk);
      n_checks++;
      if (max_bid !== 16'd10) begin
         n_fail++; $display("FAIL ret_restore: max_bid=%0d required 10", max_bid);
      end
      cyc = 0; done = 1'b0;
      while (!done && cyc < 15) begin
         seen = bid_gnt;
         if (round_over === 1'b1) done = 1'b1;
         @(posedge clk); #1;
         bid_req = bid_req & ~seen;
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (!done || winner !== 3'b001 || max_bid !== 16'd10) begin
         n_fail++;
         $display("FAIL ret_result: done=%b winner=%b max_bid=%0d required 1 001 10", done, winner, max_bid);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "bench did not complete");
   end

   initial begin
      reset = 1'b1; start = 1'b0; timer_load = '0; mask = '0; bid_req = '0; bid_amt = '0;
`ifdef RETRACT_EN
      retract = '0;
`endif
      test_reset();
      test_single_bid();
      test_three_bidders();
      test_mask();
      test_tie();
      test_last_cycle();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
`ifdef RETRACT_EN
      test_retract();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
